ps2_host_tx: RTL

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
// Inhibit, start bit, 8 data bits LSB first, odd parity, stop, device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2clk_in,
  input  logic       ps2dat_in,
  output logic       ps2clk_oe,
  output logic       ps2dat_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam int MAXC =
    (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
    INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] INH_LAST =
    CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST =
    CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    BITS,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic            clk_s1;
  logic            clk_s2;
  logic            clk_d;
  logic            dat_s1;
  logic            dat_s2;
  logic [7:0]      data_q;
  logic            par_q;
  logic [3:0]      idx_q;
  logic [CW-1:0]   cnt_q;
  logic            dat_oe_q;
  logic            ack_err_q;
  logic            timeout_q;
  logic            fall;
  logic            accept;
  logic            inh_last;
  logic            expire;
  logic            line_idle;

  assign fall      = clk_d & ~clk_s2;
  assign accept    = (state_q == IDLE) & tx_valid;
  assign inh_last  = (state_q == INHIBIT) &
                     (cnt_q == INH_LAST);
  assign expire    = ((state_q == BITS) |
                      (state_q == ACK)) &
                     (cnt_q == TO_LAST);
  assign line_idle = clk_s2 & dat_s2;

  // Two-flop synchronizers plus a delayed clock copy for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_d  <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2clk_in;
      clk_s2 <= clk_s1;
      clk_d  <= clk_s2;
      dat_s1 <= ps2dat_in;
      dat_s2 <= dat_s1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; the timer beats a coincident clock edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (tx_valid) state_d = INHIBIT;
      INHIBIT:
        if (inh_last) state_d = START;
      START:
        state_d = BITS;
      BITS:
        if (expire)
          state_d = IDLE;
        else if (fall && idx_q == 4'd9)
          state_d = ACK;
      ACK:
        if (expire)
          state_d = IDLE;
        else if (fall)
          state_d = WAIT_IDLE;
      WAIT_IDLE:
        if (line_idle) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  // Outputs; an expiring timer releases data and flags the same cycle.
  always_comb begin
    tx_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    ps2clk_oe = (state_q == INHIBIT) |
                (state_q == START);
    ps2dat_oe = dat_oe_q & ~expire;
    done      = expire |
                ((state_q == WAIT_IDLE) & line_idle);
    ack_err   = ack_err_q | expire;
    timeout   = timeout_q | expire;
  end

  // Shared counter: inhibit length, then frame timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      unique case (state_q)
        INHIBIT, BITS, ACK:
          cnt_q <= cnt_q + CW'(1);
        default:
          cnt_q <= '0;
      endcase
    end
  end

  // Byte latch, bit index and data line drive.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= '0;
      par_q    <= 1'b0;
      idx_q    <= '0;
      dat_oe_q <= 1'b0;
    end else begin
      if (accept) begin
        data_q   <= tx_data;
        par_q    <= ~^tx_data;
        dat_oe_q <= 1'b0;
      end
      if (inh_last) dat_oe_q <= 1'b1;
      if (state_q == START) idx_q <= '0;
      if (state_q == BITS && fall) begin
        idx_q <= idx_q + 4'd1;
        if (idx_q < 4'd8)
          dat_oe_q <= ~data_q[idx_q[2:0]];
        else if (idx_q == 4'd8)
          dat_oe_q <= ~par_q;
        else
          dat_oe_q <= 1'b0;
      end
      if (expire) dat_oe_q <= 1'b0;
    end
  end

  // Sticky status, cleared by the next accepted byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else if (accept) begin
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else if (expire) begin
      ack_err_q <= 1'b1;
      timeout_q <= 1'b1;
    end else if (state_q == ACK && fall) begin
      ack_err_q <= dat_s2;
    end
  end

endmodule
